// File: rtl/dotmatrix_frame_scan_if.sv
// Frame transfer handshake between the pattern source and the dot-matrix scanner.
// The source owns valid/data; the scanner owns ready.
interface dotmatrix_frame_scan_if;
  localparam int unsigned PIX_W = 35;

  logic             frame_valid;
  logic             frame_ready;
  logic [PIX_W-1:0] frame_data;

  modport master (output frame_valid, output frame_data, input frame_ready);
  modport slave  (input frame_valid, input frame_data, output frame_ready);
endinterface

// File: rtl/dotmatrix_frame_scan.sv
// Row-multiplexed 5x7 dot-matrix driver with a double-buffered bitmap
// (shadow + active) and a blanking gap before every driven row.
module dotmatrix_frame_scan #(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  input  logic                  en,
  dotmatrix_frame_scan_if.slave fbus,
  output logic [4:0]            row,
  output logic [6:0]            column,
  output logic                  frame_done
);

  localparam int unsigned ROWS       = 5;
  localparam int unsigned COLS       = 7;
  localparam int unsigned PIX_W      = ROWS * COLS;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [ROWS-1:0]    row_nxt;
  logic [COLS-1:0]    column_nxt;
  logic               done_nxt;
  logic               swap;
  logic               accept;
  logic               pending;
  logic [PIX_W-1:0]   shadow;
  logic [PIX_W-1:0]   active;
  logic [COLS-1:0]    slice;

  assign fbus.frame_ready = !pending;
  assign accept           = fbus.frame_valid && !pending;

  // Column pattern of the row currently indexed
  always_comb begin
    slice = '0;
    case (idx)
      IDX_W'(0): slice = active[0*COLS +: COLS];
      IDX_W'(1): slice = active[1*COLS +: COLS];
      IDX_W'(2): slice = active[2*COLS +: COLS];
      IDX_W'(3): slice = active[3*COLS +: COLS];
      IDX_W'(4): slice = active[4*COLS +: COLS];
      default:   slice = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and registered-output values; swap only lands on a frame boundary
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    row_nxt    = '0;
    column_nxt = '0;
    done_nxt   = 1'b0;
    swap       = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = BLANK;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          swap      = pending;
        end
        BLANK: begin
          if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            state_nxt  = DRIVE;
            cnt_nxt    = '0;
            row_nxt    = ROWS'(1) << idx;
            column_nxt = slice;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (cnt == CNT_W'(DWELL_CYCLES - 1)) begin
            state_nxt = BLANK;
            cnt_nxt   = '0;
            if (idx == IDX_W'(ROWS - 1)) begin
              idx_nxt  = '0;
              done_nxt = 1'b1;
              swap     = pending;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end else begin
            cnt_nxt    = cnt + CNT_W'(1);
            row_nxt    = row;
            column_nxt = column;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      cnt        <= '0;
      row        <= '0;
      column     <= '0;
      frame_done <= 1'b0;
    end else begin
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      row        <= row_nxt;
      column     <= column_nxt;
      frame_done <= done_nxt;
    end
  end

  // Double buffer: accept and swap are mutually exclusive because ready = !pending
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      shadow  <= '0;
      active  <= '0;
    end else if (swap) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (accept) begin
      shadow  <= fbus.frame_data;
      pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dotmatrix_frame_scan.sv
// Bench for dotmatrix_frame_scan: a scan-position model driven by elapsed cycles
// is compared every cycle, plus hand-computed checkpoints for the main scenarios.
module tb_dotmatrix_frame_scan;
  localparam int DWELL = 4;
  localparam int BLANK = 2;
  localparam int RP    = BLANK + DWELL;
  localparam int FP    = 5 * RP;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [4:0]  row;
  logic [6:0]  column;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  dotmatrix_frame_scan_if fif ();

  dotmatrix_frame_scan #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)) dut (
    .CLOCK_50   (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fbus       (fif.slave),
    .row        (row),
    .column     (column),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: t counts cycles since the scan started; outputs follow from t alone
  bit          m_run    = 1'b0;
  int          m_t      = 0;
  logic        m_pend   = 1'b0;
  logic [34:0] m_shadow = '0;
  logic [34:0] m_active = '0;
  logic [4:0]  e_row    = '0;
  logic [6:0]  e_col    = '0;
  logic        e_done   = 1'b0;
  bit          m_acc, m_bnd;
  int          m_p, m_r, m_w;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_pend = 0; m_shadow = '0; m_active = '0;
      e_row = '0; e_col = '0; e_done = 1'b0;
    end else begin
      m_acc = fif.frame_valid && !m_pend;
      m_bnd = 0;
      if (!en) begin
        m_run = 0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1; m_t = 0; m_bnd = 1;
      end else begin
        m_t++;
        m_bnd = (m_t % FP) == 0;
      end
      if (m_bnd && m_pend) begin
        m_active = m_shadow; m_pend = 0;
      end else if (m_acc) begin
        m_shadow = fif.frame_data; m_pend = 1;
      end
      e_row = '0; e_col = '0; e_done = 1'b0;
      if (m_run) begin
        m_p = m_t % FP;
        m_r = m_p / RP;
        m_w = m_p % RP;
        if (m_w >= BLANK) begin
          e_row = 5'(1 << m_r);
          e_col = m_active[m_r*7 +: 7];
        end
        e_done = (m_p == 0) && (m_t > 0);
      end
    end
  end

  always @(negedge clk) begin
    check("row", 64'(row), 64'(e_row));
    check("column", 64'(column), 64'(e_col));
    check("frame_done", 64'(frame_done), 64'(e_done));
    check("frame_ready", 64'(fif.frame_ready), 64'(!m_pend));
  end

  task automatic wait_row(input logic [4:0] target, input string name);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (row == target) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: row %0h never seen within bound", name, target);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [34:0] fa, fb;
  bit got_ready;

  initial begin
    rst_n = 1'b0; en = 1'b0;
    fif.frame_valid = 1'b0; fif.frame_data = '0;
    repeat (2) @(negedge clk);
    check("reset_row", 64'(row), 64'h0);
    check("reset_ready", 64'(fif.frame_ready), 64'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Free-running scan of a blank image
    en = 1'b1;
    for (int k = 1; k <= 61; k++) begin
      @(negedge clk);
      if (k == 3)  check("t1_first_row", 64'(row), 64'h01);
      if (k == 7)  check("t1_row0_blank", 64'(row), 64'h00);
      if (k == 31) check("t1_done_30", 64'(frame_done), 64'h1);
      if (k == 32) check("t1_done_pulse", 64'(frame_done), 64'h0);
      if (k == 61) check("t1_done_60", 64'(frame_done), 64'h1);
    end

    // Load rows 0 and 4 while dark, then start
    en = 1'b0;
    @(negedge clk);
    fif.frame_valid = 1'b1; fif.frame_data = 35'h7_F000_007F;
    @(negedge clk);
    fif.frame_valid = 1'b0;
    check("t2_pending", 64'(fif.frame_ready), 64'h0);
    en = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1)  check("t2_swap_ready", 64'(fif.frame_ready), 64'h1);
      if (k == 3)  check("t2_row0_col", 64'(column), 64'h7F);
      if (k == 9)  check("t2_row1_col", 64'(column), 64'h00);
      if (k == 27) check("t2_row4_col", 64'(column), 64'h7F);
    end

    // Frame A, then B offered while A is pending
    fa = {3'($urandom), 32'($urandom)};
    fb = {3'($urandom), 32'($urandom)};
    @(negedge clk);
    fif.frame_valid = 1'b1; fif.frame_data = fa;
    @(negedge clk);
    fif.frame_data = fb;
    check("t3_b_blocked", 64'(fif.frame_ready), 64'h0);
    got_ready = 0;
    for (int i = 0; i < 100 && !got_ready; i++) begin
      @(negedge clk);
      if (fif.frame_ready) got_ready = 1;
    end
    check("t3_ready_rose", 64'(got_ready), 64'h1);
    check("t3_swap_at_done", 64'(frame_done), 64'h1);
    @(negedge clk);
    fif.frame_valid = 1'b0;
    check("t3_b_accepted", 64'(fif.frame_ready), 64'h0);
    @(negedge clk);
    check("t3_row0_shows_a", 64'(column), 64'(fa[6:0]));

    // Drop enable during row 2
    wait_row(5'b00100, "t4_wait_row2");
    en = 1'b0;
    @(negedge clk);
    check("t4_dark_row", 64'(row), 64'h0);
    check("t4_dark_col", 64'(column), 64'h0);
    en = 1'b1;
    @(negedge clk);
    check("t4_blank1", 64'(row), 64'h0);
    @(negedge clk);
    check("t4_blank2", 64'(row), 64'h0);
    @(negedge clk);
    check("t4_restart_row0", 64'(row), 64'h01);

    // Asynchronous reset in the middle of a driven row
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_row", 64'(row), 64'h0);
    check("t5_async_col", 64'(column), 64'h0);
    @(negedge clk);
    check("t5_ready", 64'(fif.frame_ready), 64'h1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_row0_after", 64'(row), 64'h01);
    check("t5_image_off", 64'(column), 64'h00);

    // Random handshake traffic and occasional enable drops
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      fif.frame_valid = 1'($urandom);
      fif.frame_data  = {3'($urandom), 32'($urandom)};
      en = ($urandom_range(0, 99) != 0);
    end
    fif.frame_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
